// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - debounced button levels to short/long press events
// Per-button hold counters feed pending flags that are granted round-robin onto one valid/ready port.
module button_event_arbiter #(
   parameter int NUM_BTN     = 4,
   parameter int IDX_W       = 2,
   parameter int COUNTER_LEN = 20,
   parameter int LONG_PRESS  = 1_000_000
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_BTN-1:0] btn_db,
   input  logic               evt_ready,
   output logic               evt_valid,
   output logic [IDX_W-1:0]   evt_id,
   output logic               evt_long,
   output logic [NUM_BTN-1:0] pending,
   output logic               overflow
);

   localparam logic [COUNTER_LEN-1:0] CNT_MAX  = COUNTER_LEN'(LONG_PRESS);
   localparam logic [COUNTER_LEN-1:0] CNT_PRE  = COUNTER_LEN'(LONG_PRESS - 1);
   localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_BTN - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic [COUNTER_LEN-1:0] cnt [NUM_BTN];
   logic [NUM_BTN-1:0]     long_set;
   logic [NUM_BTN-1:0]     short_set;
   logic [NUM_BTN-1:0]     long_pend;
   logic [NUM_BTN-1:0]     short_pend;
   logic [NUM_BTN-1:0]     long_clr;
   logic [NUM_BTN-1:0]     short_clr;
   logic [NUM_BTN-1:0]     drop;
   logic [IDX_W-1:0]       last_grant;
   logic [IDX_W-1:0]       last_grant_d;
   logic [IDX_W-1:0]       evt_id_d;
   logic                   evt_valid_d;
   logic                   evt_long_d;
   logic                   found;
   logic [IDX_W-1:0]       sel;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            if (!btn_db[i])
               cnt[i] <= '0;
            else if (cnt[i] != CNT_MAX)
               cnt[i] <= cnt[i] + COUNTER_LEN'(1);
         end
      end
   end

   // Long fires on the edge the counter reaches LONG_PRESS; a saturated counter never yields a short.
   always_comb begin
      long_set  = '0;
      short_set = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         long_set[i]  = btn_db[i] && (cnt[i] == CNT_PRE);
         short_set[i] = !btn_db[i] && (cnt[i] != '0) && (cnt[i] < CNT_MAX);
      end
   end

   assign pending = short_pend | long_pend;

   always_comb begin : rr_search
      int idx;
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      for (int k = 1; k <= NUM_BTN; k++) begin
         idx = int'(last_grant) + k;
         if (idx >= NUM_BTN) idx = idx - NUM_BTN;
         if (!found && pending[idx]) begin
            found = 1'b1;
            sel   = IDX_W'(idx);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      evt_valid_d  = evt_valid;
      evt_id_d     = evt_id;
      evt_long_d   = evt_long;
      last_grant_d = last_grant;
      short_clr    = '0;
      long_clr     = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               evt_valid_d = 1'b1;
               evt_id_d    = sel;
               evt_long_d  = long_pend[sel];
               if (long_pend[sel])
                  long_clr[sel] = 1'b1;
               else
                  short_clr[sel] = 1'b1;
               state_d = OFFER;
            end
         end
         OFFER: begin
            if (evt_ready) begin
               last_grant_d = evt_id;
               evt_valid_d  = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A set landing on the clearing edge is kept and does not count as a drop.
   assign drop = (short_set & short_pend & ~short_clr) | (long_set & long_pend & ~long_clr);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         evt_valid  <= 1'b0;
         evt_id     <= '0;
         evt_long   <= 1'b0;
         last_grant <= LAST_IDX;
         short_pend <= '0;
         long_pend  <= '0;
         overflow   <= 1'b0;
      end else begin
         state_q    <= state_d;
         evt_valid  <= evt_valid_d;
         evt_id     <= evt_id_d;
         evt_long   <= evt_long_d;
         last_grant <= last_grant_d;
         short_pend <= short_set | (short_pend & ~short_clr);
         long_pend  <= long_set | (long_pend & ~long_clr);
         overflow   <= |drop;
      end
   end

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb/tb_button_event_arbiter.sv - directed vector bench for button_event_arbiter
// Runs with LONG_PRESS=8 so long presses fit in a few cycles.
module tb_button_event_arbiter;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] btn_db = 4'b0000;
   logic       evt_ready = 1'b0;
   logic       evt_valid;
   logic [1:0] evt_id;
   logic       evt_long;
   logic [3:0] pending;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   button_event_arbiter #(
      .NUM_BTN    (4),
      .IDX_W      (2),
      .COUNTER_LEN(4),
      .LONG_PRESS (8)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .btn_db   (btn_db),
      .evt_ready(evt_ready),
      .evt_valid(evt_valid),
      .evt_id   (evt_id),
      .evt_long (evt_long),
      .pending  (pending),
      .overflow (overflow)
   );

   typedef struct {
      bit         rst;
      logic [3:0] btn;
      logic       rdy;
      logic       v;
      logic [1:0] id;
      logic       lg;
      logic [3:0] pend;
      logic       ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit rst, input logic [3:0] btn, input logic rdy, input logic v,
                      input logic [1:0] id, input logic lg, input logic [3:0] pend, input logic ovf);
      vec_t t;
      t.rst = rst; t.btn = btn; t.rdy = rdy; t.v = v;
      t.id = id; t.lg = lg; t.pend = pend; t.ovf = ovf;
      vecs.push_back(t);
   endtask

   task automatic check(input string name, input bit chk_id, input logic v, input logic [1:0] id,
                        input logic lg, input logic [3:0] pend, input logic ovf);
      logic ok;
      checks++;
      ok = (evt_valid === v) && (pending === pend) && (overflow === ovf);
      if (v || chk_id) ok = ok && (evt_id === id) && (evt_long === lg);
      if (!ok) begin
         errors++;
         $display("FAIL %s: got valid=%b id=%0d long=%b pending=%b overflow=%b, expected valid=%b id=%0d long=%b pending=%b overflow=%b",
                  name, evt_valid, evt_id, evt_long, pending, overflow, v, id, lg, pend, ovf);
      end
   endtask

   task automatic step(input string name, input logic [3:0] btn, input logic rdy, input logic v,
                       input logic [1:0] id, input logic lg, input logic [3:0] pend, input logic ovf);
      btn_db = btn;
      evt_ready = rdy;
      @(posedge clk);
      #1;
      check(name, 1'b0, v, id, lg, pend, ovf);
   endtask

   task automatic do_reset(input logic [3:0] held);
      reset_n = 1'b0;
      btn_db = held;
      evt_ready = 1'b0;
      #1;
      check("reset_state", 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      // short press on button 2
      add(1, 4'b0100, 1, 0, 0, 0, 4'b0000, 0);
      add(0, 4'b0100, 1, 0, 0, 0, 4'b0000, 0);
      add(0, 4'b0100, 1, 0, 0, 0, 4'b0000, 0);
      add(0, 4'b0000, 1, 0, 0, 0, 4'b0100, 0);
      add(0, 4'b0000, 1, 1, 2, 0, 4'b0000, 0);
      add(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
      add(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
      // long press on button 1 held 20 cycles
      for (int k = 1; k <= 7; k++) add(k == 1, 4'b0010, 1, 0, 0, 0, 4'b0000, 0);
      add(0, 4'b0010, 1, 0, 0, 0, 4'b0010, 0);
      add(0, 4'b0010, 1, 1, 1, 1, 4'b0000, 0);
      add(0, 4'b0010, 1, 0, 0, 0, 4'b0000, 0);
      for (int k = 0; k < 10; k++) add(0, 4'b0010, 1, 0, 0, 0, 4'b0000, 0);
      for (int k = 0; k < 3; k++) add(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
      // round robin 0,1,3 with a fresh press on 0 landing after 3
      add(1, 4'b1011, 1, 0, 0, 0, 4'b0000, 0);
      add(0, 4'b1011, 1, 0, 0, 0, 4'b0000, 0);
      add(0, 4'b0000, 1, 0, 0, 0, 4'b1011, 0);
      add(0, 4'b0001, 1, 1, 0, 0, 4'b1010, 0);
      add(0, 4'b0001, 1, 0, 0, 0, 4'b1010, 0);
      add(0, 4'b0000, 1, 1, 1, 0, 4'b1001, 0);
      add(0, 4'b0000, 1, 0, 0, 0, 4'b1001, 0);
      add(0, 4'b0000, 1, 1, 3, 0, 4'b0001, 0);
      add(0, 4'b0000, 1, 0, 0, 0, 4'b0001, 0);
      add(0, 4'b0000, 1, 1, 0, 0, 4'b0000, 0);
      add(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
      // backpressure: second press pends, third overflows
      add(1, 4'b0001, 0, 0, 0, 0, 4'b0000, 0);
      add(0, 4'b0000, 0, 0, 0, 0, 4'b0001, 0);
      add(0, 4'b0000, 0, 1, 0, 0, 4'b0000, 0);
      add(0, 4'b0001, 0, 1, 0, 0, 4'b0000, 0);
      add(0, 4'b0000, 0, 1, 0, 0, 4'b0001, 0);
      add(0, 4'b0001, 0, 1, 0, 0, 4'b0001, 0);
      add(0, 4'b0000, 0, 1, 0, 0, 4'b0001, 1);
      add(0, 4'b0000, 0, 1, 0, 0, 4'b0001, 0);
      add(0, 4'b0000, 1, 0, 0, 0, 4'b0001, 0);
      add(0, 4'b0000, 1, 1, 0, 0, 4'b0000, 0);
      add(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
      add(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
      // set and clear of short_pend[3] on the same edge
      add(1, 4'b1001, 0, 0, 0, 0, 4'b0000, 0);
      add(0, 4'b0000, 0, 0, 0, 0, 4'b1001, 0);
      add(0, 4'b1000, 0, 1, 0, 0, 4'b1000, 0);
      add(0, 4'b1000, 1, 0, 0, 0, 4'b1000, 0);
      add(0, 4'b0000, 1, 1, 3, 0, 4'b1000, 0);
      add(0, 4'b0000, 1, 0, 0, 0, 4'b1000, 0);
      add(0, 4'b0000, 1, 1, 3, 0, 4'b0000, 0);
      add(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);

      foreach (vecs[i]) begin
         if (vecs[i].rst) do_reset(4'b0000);
         btn_db = vecs[i].btn;
         evt_ready = vecs[i].rdy;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), 1'b0, vecs[i].v, vecs[i].id, vecs[i].lg, vecs[i].pend, vecs[i].ovf);
      end

      // reset mid-OFFER with button 0 held across it
      do_reset(4'b0000);
      step("t6_press1", 4'b0010, 0, 0, 0, 0, 4'b0000, 0);
      step("t6_rel1",   4'b0000, 0, 0, 0, 0, 4'b0010, 0);
      step("t6_offer",  4'b0001, 0, 1, 1, 0, 4'b0000, 0);
      step("t6_hold",   4'b0001, 0, 1, 1, 0, 4'b0000, 0);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("t6_async_reset", 1'b1, 0, 0, 0, 4'b0000, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 1; k <= 7; k++) step($sformatf("t6_count%0d", k), 4'b0001, 0, 0, 0, 0, 4'b0000, 0);
      step("t6_long_pend", 4'b0001, 0, 0, 0, 0, 4'b0001, 0);
      step("t6_long_evt",  4'b0001, 0, 1, 0, 1, 4'b0000, 0);
      step("t6_release",   4'b0000, 1, 0, 0, 0, 4'b0000, 0);
      step("t6_quiet",     4'b0000, 1, 0, 0, 0, 4'b0000, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Turns the debounced levels of up to NUM_BTN `button_debounce` instances into discrete short-press and long-press events. Events are queued as per-button pending flags and granted round-robin onto a single valid/ready event port. The block sits between the debouncer bank and the consuming control FSM, so every user input reaches the consumer as exactly one handshake.

## Interface
- NUM_BTN, 4: number of debounced button inputs, legal 2..8
- IDX_W, 2: width of event index; must satisfy 2**IDX_W >= NUM_BTN
- COUNTER_LEN, 20: width of each per-button hold counter
- LONG_PRESS, 1_000_000: hold cycles that qualify as a long press; must satisfy 1 < LONG_PRESS < 2**COUNTER_LEN

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- btn_db  input  NUM_BTN  debounced button levels, 1 = pressed, synchronous to clk
- evt_ready  input  1  consumer accepts the offered event
- evt_valid  output  1  event offered, reset 0
- evt_id  output  IDX_W  button index of offered event, reset 0
- evt_long  output  1  1 = long press, 0 = short press, reset 0
- pending  output  NUM_BTN  OR of short and long pending flags per button, reset 0
- overflow  output  1  one-cycle pulse when an event is dropped, reset 0

## Operation
Per-button hold counter `cnt[i]`:
- While btn_db[i] = 0, cnt[i] is 0 on the next edge.
- While btn_db[i] = 1, cnt[i] increments each edge and saturates at LONG_PRESS.
- Long event: when cnt[i] transitions LONG_PRESS-1 -> LONG_PRESS, set long_pend[i]. This fires once per press, while the button is still held.
- Short event: on an edge where btn_db[i] = 0 and 0 < cnt[i] < LONG_PRESS, set short_pend[i].
- Release after a long press (cnt[i] = LONG_PRESS) produces no event.

Overflow:
- If an event would set a pending flag that is already 1 and is not being cleared this edge, the event is dropped.
- overflow pulses high for one cycle. Multiple drops in the same cycle give a single pulse.

Output FSM, two states:
- IDLE: evt_valid = 0. If any pending bit is set:
  - Select button i by round-robin, searching last_grant+1, last_grant+2, ... mod NUM_BTN.
  - Within the selected button, long_pend has priority over short_pend.
  - Load evt_id = i and evt_long accordingly, clear the chosen flag, set evt_valid = 1, go to OFFER.
- OFFER: evt_valid, evt_id and evt_long are held stable until evt_ready = 1 is sampled. On that edge: last_grant <= evt_id, evt_valid <= 0, go to IDLE.
- evt_ready while in IDLE is ignored.
- last_grant resets to NUM_BTN-1, so button 0 has first priority after reset.

Simultaneous set and clear of the same flag on one edge: set wins, flag stays 1, no overflow.

The other flag of a granted button stays pending and is serviced on a later grant.

Reset (async, any time, including mid-OFFER):
- Clears all counters, pending flags, the FSM, and the outputs to their reset values.
- An offered event is lost.
- A button held across reset deassertion counts from 0 and can yield a long event, or a short event on release.

## Timing
- Short press: btn_db[i] sampled low at edge e (after k cycles high, 0 < k < LONG_PRESS) -> short_pend[i] = 1 after e -> evt_valid = 1 after e+1, if the FSM is IDLE.
- Long press: btn_db[i] high at LONG_PRESS consecutive edges -> long_pend[i] set at the LONG_PRESS-th edge -> evt_valid one edge later.
- Throughput: at most one event per 2 cycles, because OFFER always returns through IDLE for at least one cycle.
- pending reflects the registered flags with no combinational path from btn_db.
- overflow is registered, aligned with the edge that drops the event.

## Test plan
- Short press: LONG_PRESS=8, btn_db[2] high 3 cycles then low, evt_ready=1 -> one event evt_id=2, evt_long=0, evt_valid high exactly 1 cycle, asserted 2 edges after release is sampled.
- Long press: btn_db[1] held 20 cycles -> long event (id=1, evt_long=1) offered after the 8th high edge while still held; release produces no further event.
- Round-robin: short events pending on buttons 0, 1 and 3 at once, evt_ready=1 -> grant order 0, 1, 3. A new press on 0 arriving during those grants is granted after 3.
- Backpressure and overflow: evt_ready=0, button 0 pressed twice (short) while its first event is in OFFER, then a third time -> second event pends; third pulses overflow for 1 cycle. evt_id/evt_long stay stable throughout; after evt_ready rises, exactly 2 events for button 0 are delivered.
- Simultaneous set/clear: a new short event on button 3 lands on the same edge IDLE grants button 3's short flag -> pending[3] stays 1, no overflow, second event delivered next.
- Reset mid-operation: reset_n low for 2 cycles during OFFER with btn_db[0] held -> all outputs 0 immediately. After release the held button yields a long event 8 edges later.
